// File: rtl/matrix_gen_3x3.sv
// -----------------------------------------------------------------------------
// matrix_gen_3x3
// Builds a zero-padded 3x3 pixel neighbourhood from a raster pixel stream.
// Two line buffers hold the previous two lines. Per-row column shift registers
// form the window. Sync signals are delayed to match the 2-clk data latency.
//
// Ports
//   clk                 pixel clock
//   rst_n               asynchronous active-low reset
//   per_frame_vsync     frame sync in (active high)
//   per_frame_href      line valid in; one pixel accepted per clk while high
//   per_frame_data      input pixel [DW]
//   data11..data13      window top row    (line r-2), columns c-2, c-1, c
//   data21..data23      window middle row (line r-1)
//   data31..data33      window bottom row (line r, current line)
//   matrix_frame_vsync  vsync delayed 2 clk
//   matrix_frame_href   href delayed 2 clk, qualifies data11..data33
// -----------------------------------------------------------------------------
module matrix_gen_3x3 #(
   parameter int IMG_W = 640,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          per_frame_vsync,
   input  logic          per_frame_href,
   input  logic [DW-1:0] per_frame_data,
   output logic [DW-1:0] data11,
   output logic [DW-1:0] data12,
   output logic [DW-1:0] data13,
   output logic [DW-1:0] data21,
   output logic [DW-1:0] data22,
   output logic [DW-1:0] data23,
   output logic [DW-1:0] data31,
   output logic [DW-1:0] data32,
   output logic [DW-1:0] data33,
   output logic          matrix_frame_vsync,
   output logic          matrix_frame_href
);

   localparam int CW    = $clog2(IMG_W);
   // One extra bit so the column counter can hold IMG_W itself when IMG_W is
   // a power of two (saturation marks pixels beyond the line buffer depth).
   localparam int CNT_W = CW + 1;

   logic             r_vsync_d1, r_vsync_d2;
   logic             r_href_d1,  r_href_d2;
   logic [CNT_W-1:0] r_col;
   logic [1:0]       r_row;

   logic [DW-1:0]    r_lb1 [0:IMG_W-1];
   logic [DW-1:0]    r_lb2 [0:IMG_W-1];
   logic [DW-1:0]    r_lb1_rd, r_lb2_rd;

   logic [DW-1:0]    r_tap3;
   logic             r_q1, r_q2;

   logic             w_vsync_rise, w_href_fall, w_col_ok, w_wr;
   logic [CW-1:0]    w_addr;
   logic [DW-1:0]    w_tap1, w_tap2;

   assign w_vsync_rise = per_frame_vsync & ~r_vsync_d1;
   assign w_href_fall  = ~per_frame_href & r_href_d1;
   assign w_col_ok     = (r_col < CNT_W'(IMG_W));
   assign w_addr       = r_col[CW-1:0];
   assign w_wr         = per_frame_href & w_col_ok;

   // Sync delay lines. The first stage also serves as the edge detector.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_d1 <= 1'b0;
         r_vsync_d2 <= 1'b0;
         r_href_d1  <= 1'b0;
         r_href_d2  <= 1'b0;
      end else begin
         r_vsync_d1 <= per_frame_vsync;
         r_vsync_d2 <= r_vsync_d1;
         r_href_d1  <= per_frame_href;
         r_href_d2  <= r_href_d1;
      end
   end

   assign matrix_frame_vsync = r_vsync_d2;
   assign matrix_frame_href  = r_href_d2;

   // Column / row counters. A vsync rise takes priority over an href fall.
   // A non-zero column at href fall means the line accepted at least one pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= 2'd0;
      end else if (w_vsync_rise) begin
         r_col <= '0;
         r_row <= 2'd0;
      end else if (w_href_fall) begin
         r_col <= '0;
         if (r_col != '0 && r_row != 2'd2) r_row <= r_row + 2'd1;
      end else if (per_frame_href && w_col_ok) begin
         r_col <= r_col + CNT_W'(1);
      end
   end

   // Line buffers with read-before-write at the same address: LB2 takes LB1's
   // old word while LB1 takes the new pixel.
   // NOTE: the buffers are deliberately not reset; stale words are masked by
   // the row qualifiers below, which keeps them mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_lb1_rd      <= r_lb1[w_addr];
         r_lb2_rd      <= r_lb2[w_addr];
         r_lb2[w_addr] <= r_lb1[w_addr];
         r_lb1[w_addr] <= per_frame_data;
      end
   end

   // Tap stage: current pixel plus qualifiers telling whether the buffer reads
   // belong to this frame and to a column inside the buffer depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap3 <= '0;
         r_q1   <= 1'b0;
         r_q2   <= 1'b0;
      end else if (per_frame_href) begin
         r_tap3 <= per_frame_data;
         r_q1   <= w_col_ok && (r_row == 2'd2);
         r_q2   <= w_col_ok && (r_row != 2'd0);
      end
   end

   assign w_tap1 = r_q1 ? r_lb2_rd : '0;
   assign w_tap2 = r_q2 ? r_lb1_rd : '0;

   // Window shift registers. The first delayed-href cycle of a line loads zeros
   // into the two older columns, giving left-border padding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data11 <= '0; data12 <= '0; data13 <= '0;
         data21 <= '0; data22 <= '0; data23 <= '0;
         data31 <= '0; data32 <= '0; data33 <= '0;
      end else if (r_href_d1 && !r_href_d2) begin
         data11 <= '0; data12 <= '0; data13 <= w_tap1;
         data21 <= '0; data22 <= '0; data23 <= w_tap2;
         data31 <= '0; data32 <= '0; data33 <= r_tap3;
      end else if (r_href_d1) begin
         data11 <= data12; data12 <= data13; data13 <= w_tap1;
         data21 <= data22; data22 <= data23; data23 <= w_tap2;
         data31 <= data32; data32 <= data33; data33 <= r_tap3;
      end
   end

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_matrix_gen_3x3
// Directed bench for matrix_gen_3x3 with IMG_W=4. Frames are driven as vsync
// pulses followed by lines of pixels (value 16*r+c+1). Every post-edge output
// sample is logged by cycle number, and windows are compared against
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_matrix_gen_3x3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       per_frame_vsync;
   logic       per_frame_href;
   logic [7:0] per_frame_data;
   logic [7:0] data11, data12, data13, data21, data22, data23, data31, data32, data33;
   logic       matrix_frame_vsync, matrix_frame_href;

   matrix_gen_3x3 #(.IMG_W(4), .DW(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .per_frame_vsync   (per_frame_vsync),
      .per_frame_href    (per_frame_href),
      .per_frame_data    (per_frame_data),
      .data11            (data11),
      .data12            (data12),
      .data13            (data13),
      .data21            (data21),
      .data22            (data22),
      .data23            (data23),
      .data31            (data31),
      .data32            (data32),
      .data33            (data33),
      .matrix_frame_vsync(matrix_frame_vsync),
      .matrix_frame_href (matrix_frame_href)
   );

   always #5 clk = ~clk;

   logic [71:0] w_win;
   assign w_win = {data11, data12, data13, data21, data22, data23, data31, data32, data33};

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   logic [71:0] obs_win  [0:511];
   logic        obs_href [0:511];
   logic        obs_vs   [0:511];
   int          pc       [0:3][0:5];
   int          vs_cyc;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] win(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] d, input logic [7:0] e, input logic [7:0] f,
                                       input logic [7:0] g, input logic [7:0] h, input logic [7:0] i);
      return {a, b, c, d, e, f, g, h, i};
   endfunction

   // Drive one cycle of inputs, then log the outputs 1 ns after the edge.
   task automatic step(input logic vs, input logic hr, input logic [7:0] d);
      per_frame_vsync = vs;
      per_frame_href  = hr;
      per_frame_data  = d;
      @(posedge clk);
      #1;
      if (cyc < 511) cyc++;
      obs_win[cyc]  = w_win;
      obs_href[cyc] = matrix_frame_href;
      obs_vs[cyc]   = matrix_frame_vsync;
   endtask

   task automatic frame_start();
      step(1'b1, 1'b0, 8'h00);
      vs_cyc = cyc;
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_line(input int r, input int n);
      for (int c = 0; c < n; c++) begin
         step(1'b0, 1'b1, 8'(16 * r + c + 1));
         pc[r][c] = cyc;
      end
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst_n           = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_frame_data  = 8'h00;
      #12;
      check("rst_win",   w_win, 72'd0);
      check("rst_href",  72'(matrix_frame_href), 72'd0);
      check("rst_vsync", 72'(matrix_frame_vsync), 72'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);

      // Frame A: plain 4x4 frame
      frame_start();
      for (int r = 0; r < 4; r++) send_line(r, 4);
      check("a_vs_pre",  72'(obs_vs[vs_cyc]), 72'd0);
      check("a_vs_dly2", 72'(obs_vs[vs_cyc + 1]), 72'd1);
      check("a_w00",  obs_win[pc[0][0] + 1], win(0, 0, 0, 0, 0, 0, 0, 0, 8'h01));
      check("a_h00",  72'(obs_href[pc[0][0] + 1]), 72'd1);
      check("a_hold_win", obs_win[pc[0][3] + 2], win(0, 0, 0, 0, 0, 0, 8'h02, 8'h03, 8'h04));
      check("a_hold_href", 72'(obs_href[pc[0][3] + 2]), 72'd0);
      check("a_w10",  obs_win[pc[1][0] + 1], win(0, 0, 0, 0, 0, 8'h01, 0, 0, 8'h11));
      check("a_w11",  obs_win[pc[1][1] + 1], win(0, 0, 0, 0, 8'h01, 8'h02, 0, 8'h11, 8'h12));
      check("a_w22",  obs_win[pc[2][2] + 1],
            win(8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23));
      check("a_w33",  obs_win[pc[3][3] + 1],
            win(8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34));

      // Frame B: stale line-buffer contents must be masked on the first lines
      frame_start();
      send_line(0, 4);
      check("b_vs_dly2", 72'(obs_vs[vs_cyc + 1]), 72'd1);
      check("b_w00", obs_win[pc[0][0] + 1], win(0, 0, 0, 0, 0, 0, 0, 0, 8'h01));
      check("b_w02", obs_win[pc[0][2] + 1], win(0, 0, 0, 0, 0, 0, 8'h01, 8'h02, 8'h03));

      // Frame C: asynchronous reset in the middle of line 1
      frame_start();
      send_line(0, 4);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h12);
      #1;
      rst_n = 1'b0;
      per_frame_href = 1'b0;
      #1;
      check("c_rst_win",  w_win, 72'd0);
      check("c_rst_href", 72'(matrix_frame_href), 72'd0);
      check("c_rst_vs",   72'(matrix_frame_vsync), 72'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      frame_start();
      send_line(0, 4);
      send_line(1, 4);
      check("c_w00", obs_win[pc[0][0] + 1], win(0, 0, 0, 0, 0, 0, 0, 0, 8'h01));
      check("c_h00", 72'(obs_href[pc[0][0] + 1]), 72'd1);
      check("c_w11", obs_win[pc[1][1] + 1], win(0, 0, 0, 0, 8'h01, 8'h02, 0, 8'h11, 8'h12));

      // Frame D: line 2 is 6 pixels long, beyond the 4-deep buffers
      frame_start();
      send_line(0, 4);
      send_line(1, 4);
      send_line(2, 6);
      send_line(3, 4);
      check("d_w24", obs_win[pc[2][4] + 1],
            win(8'h03, 8'h04, 0, 8'h13, 8'h14, 0, 8'h23, 8'h24, 8'h25));
      check("d_w25", obs_win[pc[2][5] + 1],
            win(8'h04, 0, 0, 8'h14, 0, 0, 8'h24, 8'h25, 8'h26));
      check("d_w30", obs_win[pc[3][0] + 1], win(0, 0, 8'h11, 0, 0, 8'h21, 0, 0, 8'h31));
      check("d_w33", obs_win[pc[3][3] + 1],
            win(8'h12, 8'h13, 8'h14, 8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
